alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the team's combinational 32-bit ALU.
- Keeps the same 4-bit opcode map and SEL semantics. Adds a configurable datapath width, valid/ready handshakes on input and output, and registered status flags.
- Sits between the operand-fetch logic and the writeback stage. Accepts one operation per cycle when downstream is not stalled.

Parameters:
- WIDTH, 32, datapath width in bits (>= 2)

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- IN_VALID  input  1  operation offered
- IN_READY  output  1  block can accept an operation this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- INST  input  4  opcode
- SEL  input  1  select/modifier bit
- OUT_VALID  output  1  Z/flags hold a valid result
- OUT_READY  input  1  downstream accepts the result
- Z  output  WIDTH  result
- FLAG_Z  output  1  result is zero
- FLAG_N  output  1  result MSB
- FLAG_C  output  1  carry-out / no-borrow
- FLAG_V  output  1  signed overflow

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset state: while RST is high at a CLK edge, stage-1 and stage-2 valids clear, OUT_VALID=0, Z=0, all flags=0. IN_READY=1 in the first cycle after reset deasserts.
- Transfers:
  - Input transfer occurs when IN_VALID && IN_READY at a CLK edge.
  - Output transfer occurs when OUT_VALID && OUT_READY at a CLK edge.
- Stage 1: registers A, B, INST and SEL on an input transfer.
- Stage 2: computes the result from the stage-1 registers and registers Z and the flags. These are the outputs.
- Latency: 2 cycles from input transfer to OUT_VALID, with no stall.
- Throughput: 1 operation per cycle.
- Stall rules:
  - Stage 2 advances when !OUT_VALID || OUT_READY.
  - Stage 1 advances when stage 2 advances or stage 1 is empty.
  - IN_READY equals the stage-1 advance condition. It is combinational from OUT_READY, with no combinational path from IN_VALID.
- Output stability: while OUT_VALID && !OUT_READY, Z and the flags hold stable.
- Opcodes (all arithmetic mod 2^WIDTH; comparisons unsigned; result 1 zero-extended):
  - 0000: A+B
  - 0001: ~A+1
  - 0010: A&B
  - 0011: A|B
  - 0100: A^B
  - 0101: ~A
  - 0110: SEL?B:A
  - 0111: SEL?A:B
  - 1000: A-B
  - 1001: A<B
  - 1010: A<=B
  - 1011: A>B
  - 1100: A>=B
  - 1101: A==B
  - 1110: A!=B
  - 1111: B ^ {0..0,SEL}, i.e. bit 0 of B inverted when SEL=1
- Flags:
  - FLAG_Z = (Z==0); FLAG_N = Z[WIDTH-1]. Both are valid for every op.
  - FLAG_C and FLAG_V apply to ADD, NEG and SUB only.
  - ADD: C is the carry out of bit WIDTH-1.
  - SUB: C = (A>=B), i.e. no borrow.
  - NEG: computed as 0-A, so C = (A==0) and V = (A==MSB-only pattern).
  - For all other ops C=V=0.
- Simultaneous events: an input transfer and an output transfer in the same cycle are both honoured; the pipeline stays full.
- Reset mid-operation: all in-flight operations are discarded without being output.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- Defined: ADD, SUB and NEG saturate on signed overflow. Positive overflow yields 0111..1 and negative overflow yields 1000..0. FLAG_V still reports that overflow occurred. FLAG_Z and FLAG_N reflect the saturated Z. FLAG_C reflects the unsaturated operation.
- Undefined: results wrap modulo 2^WIDTH.

Test Plan:
- Single ADD, WIDTH=32, A=0x7FFFFFFF, B=1, OUT_READY=1 -> OUT_VALID exactly 2 cycles after acceptance; Z=0x80000000, V=1, N=1, C=0. With ALU_PIPE_SAT_EN: Z=0x7FFFFFFF, V=1.
- SUB A=5, B=7 -> Z=0xFFFFFFFE, C=0, N=1. SUB A=7, B=7 -> Z=0, FLAG_Z=1, C=1.
- Back-to-back: 16 ops, one per cycle covering every opcode (e.g. 1111 with B=0x10, SEL=1 -> Z=0x11; 1001 with A=1, B=2 -> Z=1) -> 16 consecutive OUT_VALID cycles, results in order.
- Backpressure: OUT_READY=0 for 5 cycles while IN_VALID=1 -> IN_READY drops after 2 accepts; Z held stable; no loss or duplication after OUT_READY=1.
- NEG A=0 -> Z=0, C=1, V=0. NEG A=0x80000000 -> Z=0x80000000, V=1 (saturated build: Z=0x7FFFFFFF).
- RST asserted for 1 cycle with both stages full -> next cycle OUT_VALID=0, Z=0, flags=0, IN_READY=1; earlier ops never appear.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes and registered status flags.
// Optional build macro ALU_PIPE_SAT_EN: ADD/SUB/NEG saturate on signed overflow.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       INST,
  input  logic             SEL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Z,
  output logic             FLAG_Z,
  output logic             FLAG_N,
  output logic             FLAG_C,
  output logic             FLAG_V
);

  localparam int MSB = WIDTH - 1;

`ifdef ALU_PIPE_SAT_EN
  // A wrapped overflow result carries the wrong sign, so its MSB picks the clamp direction.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] wrapped, input logic ovf);
    if (!ovf) return wrapped;
    return wrapped[MSB] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  endfunction
`endif

  logic             vld_p1, vld_p2;
  logic [WIDTH-1:0] a_p1, b_p1;
  logic [3:0]       inst_p1;
  logic             sel_p1;
  logic [WIDTH-1:0] z_p2;
  logic             fz_p2, fn_p2, fc_p2, fv_p2;
  logic             adv1, adv2;

  assign adv2     = !vld_p2 || OUT_READY;
  assign adv1     = adv2 || !vld_p1;
  assign IN_READY = adv1;

  // ---- stage 1: operand capture ----
  always_ff @(posedge CLK) begin
    if (adv1 && IN_VALID) begin
      a_p1    <= A;
      b_p1    <= B;
      inst_p1 <= INST;
      sel_p1  <= SEL;
    end
  end

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]          sum, diff;
  logic signed [WIDTH-1:0] neg;
  logic [WIDTH-1:0]        res, z_n;
  logic                    c_n, v_n;

  assign a_s = a_p1;
  assign b_s = b_p1;

  always_comb begin
    sum  = {1'b0, a_p1} + {1'b0, b_p1};
    diff = {1'b0, a_p1} - {1'b0, b_p1};
    neg  = -a_s;
    res  = '0;
    c_n  = 1'b0;
    v_n  = 1'b0;
    case (inst_p1)
      4'h0: begin
        res = sum[MSB:0];
        c_n = sum[WIDTH];
        v_n = (a_s[MSB] == b_s[MSB]) && (sum[MSB] != a_s[MSB]);
      end
      4'h1: begin
        res = neg;
        c_n = (a_p1 == '0);
        v_n = (a_p1 == {1'b1, {(WIDTH-1){1'b0}}});
      end
      4'h2: res = a_p1 & b_p1;
      4'h3: res = a_p1 | b_p1;
      4'h4: res = a_p1 ^ b_p1;
      4'h5: res = ~a_p1;
      4'h6: res = sel_p1 ? b_p1 : a_p1;
      4'h7: res = sel_p1 ? a_p1 : b_p1;
      4'h8: begin
        res = diff[MSB:0];
        c_n = !diff[WIDTH];
        v_n = (a_s[MSB] != b_s[MSB]) && (diff[MSB] != a_s[MSB]);
      end
      4'h9: res = {{(WIDTH-1){1'b0}}, (a_p1 <  b_p1)};
      4'hA: res = {{(WIDTH-1){1'b0}}, (a_p1 <= b_p1)};
      4'hB: res = {{(WIDTH-1){1'b0}}, (a_p1 >  b_p1)};
      4'hC: res = {{(WIDTH-1){1'b0}}, (a_p1 >= b_p1)};
      4'hD: res = {{(WIDTH-1){1'b0}}, (a_p1 == b_p1)};
      4'hE: res = {{(WIDTH-1){1'b0}}, (a_p1 != b_p1)};
      default: res = b_p1 ^ {{(WIDTH-1){1'b0}}, sel_p1};
    endcase
`ifdef ALU_PIPE_SAT_EN
    z_n = saturate(res, v_n);
`else
    z_n = res;
`endif
  end

  // ---- stage 2: result and flag registers (block outputs) ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      z_p2   <= '0;
      fz_p2  <= 1'b0;
      fn_p2  <= 1'b0;
      fc_p2  <= 1'b0;
      fv_p2  <= 1'b0;
    end else begin
      if (adv1) vld_p1 <= IN_VALID;
      if (adv2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          z_p2  <= z_n;
          fz_p2 <= (z_n == '0);
          fn_p2 <= z_n[MSB];
          fc_p2 <= c_n;
          fv_p2 <= v_n;
        end
      end
    end
  end

  assign OUT_VALID = vld_p2;
  assign Z         = z_p2;
  assign FLAG_Z    = fz_p2;
  assign FLAG_N    = fn_p2;
  assign FLAG_C    = fc_p2;
  assign FLAG_V    = fv_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized self-checking bench for alu_pipe (WIDTH=32) against an arithmetic reference model.
module tb_alu_pipe;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        CLK, RST, IN_VALID, IN_READY, SEL, OUT_VALID, OUT_READY;
  logic [31:0] A, B, Z;
  logic [3:0]  INST;
  logic        FLAG_Z, FLAG_N, FLAG_C, FLAG_V;

  alu_pipe #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .INST(INST), .SEL(SEL),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .Z(Z),
    .FLAG_Z(FLAG_Z), .FLAG_N(FLAG_N), .FLAG_C(FLAG_C), .FLAG_V(FLAG_V)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] z;
    logic fz, fn, fc, fv;
  } res_t;

  int   n_vec  = 0;
  int   n_miss = 0;
  res_t exp_q[$];
  logic accepted = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed/unsigned arithmetic in 64 bits, then range-check.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic s);
    res_t r;
    longint t, sa, sb;
    longint unsigned ua, ub;
    logic arith;
    sa = $signed(a); sb = $signed(b);
    ua = {32'b0, a}; ub = {32'b0, b};
    r = '0; t = 0; arith = 1'b0;
    case (op)
      4'd0:  begin t = sa + sb; r.fc = (ua + ub) >= 64'h1_0000_0000; arith = 1'b1; end
      4'd1:  begin t = -sa;     r.fc = (a == 32'd0);                 arith = 1'b1; end
      4'd2:  r.z = a & b;
      4'd3:  r.z = a | b;
      4'd4:  r.z = a ^ b;
      4'd5:  r.z = ~a;
      4'd6:  r.z = s ? b : a;
      4'd7:  r.z = s ? a : b;
      4'd8:  begin t = sa - sb; r.fc = (ua >= ub); arith = 1'b1; end
      4'd9:  r.z = (a <  b) ? 32'd1 : 32'd0;
      4'd10: r.z = (a <= b) ? 32'd1 : 32'd0;
      4'd11: r.z = (a >  b) ? 32'd1 : 32'd0;
      4'd12: r.z = (a >= b) ? 32'd1 : 32'd0;
      4'd13: r.z = (a == b) ? 32'd1 : 32'd0;
      4'd14: r.z = (a != b) ? 32'd1 : 32'd0;
      default: r.z = s ? (b ^ 32'd1) : b;
    endcase
    if (arith) begin
      r.fv = (t > SMAX) || (t < SMIN);
`ifdef ALU_PIPE_SAT_EN
      if (t > SMAX)      r.z = 32'h7FFF_FFFF;
      else if (t < SMIN) r.z = 32'h8000_0000;
      else               r.z = t[31:0];
`else
      r.z = t[31:0];
`endif
    end
    r.fz = (r.z == 32'd0);
    r.fn = r.z[31];
    return r;
  endfunction

  logic        hold_arm = 1'b0;
  logic [35:0] held;
  int          run_len = 0;
  int          last_run = 0;
  res_t        e;

  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      hold_arm = 1'b0;
      run_len  = 0;
    end else begin
      if (hold_arm)
        check("hold", {28'b0, Z, FLAG_Z, FLAG_N, FLAG_C, FLAG_V}, {28'b0, held});
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("z", {32'b0, Z}, {32'b0, e.z});
          check("flags", {60'b0, FLAG_Z, FLAG_N, FLAG_C, FLAG_V}, {60'b0, e.fz, e.fn, e.fc, e.fv});
        end
        run_len++;
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
      hold_arm = OUT_VALID && !OUT_READY;
      held     = {Z, FLAG_Z, FLAG_N, FLAG_C, FLAG_V};
      if (IN_VALID && IN_READY) exp_q.push_back(model(A, B, INST, SEL));
    end
  end

  task automatic to_pos();
    @(posedge CLK); #1;
  endtask

  task automatic tick();
    @(negedge CLK);
    accepted = IN_VALID && IN_READY;
    to_pos();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op();
    A = pick(); B = pick(); INST = 4'($urandom); SEL = 1'($urandom);
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic s,
                         input logic [31:0] ez, input logic [3:0] ef);
    A = a; B = b; INST = op; SEL = s; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(negedge CLK);
    check({tag, "_acc"}, {63'b0, IN_READY}, 64'd1);
    to_pos();
    IN_VALID = 1'b0;
    @(negedge CLK);
    check({tag, "_lat1"}, {63'b0, OUT_VALID}, 64'd0);
    to_pos();
    @(negedge CLK);
    check({tag, "_lat2"}, {63'b0, OUT_VALID}, 64'd1);
    check({tag, "_z"}, {32'b0, Z}, {32'b0, ez});
    check({tag, "_f"}, {60'b0, FLAG_Z, FLAG_N, FLAG_C, FLAG_V}, {60'b0, ef});
    to_pos();
  endtask

  initial begin
    int n_acc;
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    A = '0; B = '0; INST = '0; SEL = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    @(negedge CLK);
    check("rst_ovalid", {63'b0, OUT_VALID}, 64'd0);
    check("rst_z", {32'b0, Z}, 64'd0);
    check("rst_flags", {60'b0, FLAG_Z, FLAG_N, FLAG_C, FLAG_V}, 64'd0);
    check("rst_iready", {63'b0, IN_READY}, 64'd1);
    to_pos();

    // Directed corner cases (flags ordered Z,N,C,V).
`ifdef ALU_PIPE_SAT_EN
    run_one("add_ovf", 32'h7FFF_FFFF, 32'd1, 4'd0, 1'b0, 32'h7FFF_FFFF, 4'b0001);
    run_one("neg_min", 32'h8000_0000, 32'd0, 4'd1, 1'b0, 32'h7FFF_FFFF, 4'b0001);
`else
    run_one("add_ovf", 32'h7FFF_FFFF, 32'd1, 4'd0, 1'b0, 32'h8000_0000, 4'b0101);
    run_one("neg_min", 32'h8000_0000, 32'd0, 4'd1, 1'b0, 32'h8000_0000, 4'b0101);
`endif
    run_one("sub_neg", 32'd5, 32'd7, 4'd8, 1'b0, 32'hFFFF_FFFE, 4'b0100);
    run_one("sub_eq",  32'd7, 32'd7, 4'd8, 1'b0, 32'd0, 4'b1010);
    run_one("neg_0",   32'd0, 32'd9, 4'd1, 1'b0, 32'd0, 4'b1010);
    run_one("xorsel",  32'd3, 32'h10, 4'd15, 1'b1, 32'h11, 4'b0000);
    run_one("ltu",     32'd1, 32'd2, 4'd9, 1'b0, 32'd1, 4'b0000);

    // Back-to-back: every opcode once, one per cycle.
    OUT_READY = 1'b1; IN_VALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_op();
      INST = 4'(i);
      if (i == 15) begin B = 32'h10; SEL = 1'b1; end
      if (i == 9)  begin A = 32'd1;  B = 32'd2;  end
      tick();
      check("b2b_acc", {63'b0, accepted}, 64'd1);
    end
    IN_VALID = 1'b0;
    repeat (4) tick();
    check("b2b_run", 64'(last_run), 64'd16);

    // Backpressure: downstream stalled for 5 cycles.
    OUT_READY = 1'b0; IN_VALID = 1'b1; rand_op(); n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (accepted) begin n_acc++; rand_op(); end
    end
    check("bp_accepts", 64'(n_acc), 64'd2);
    check("bp_iready", {63'b0, IN_READY}, 64'd0);
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (5) tick();
    check("bp_drain", 64'(exp_q.size()), 64'd0);

    // Reset with both stages full; the two ops must never appear.
    OUT_READY = 1'b0; IN_VALID = 1'b1; rand_op();
    tick(); rand_op(); tick();
    IN_VALID = 1'b0; RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("mrst_ovalid", {63'b0, OUT_VALID}, 64'd0);
    check("mrst_z", {32'b0, Z}, 64'd0);
    check("mrst_flags", {60'b0, FLAG_Z, FLAG_N, FLAG_C, FLAG_V}, 64'd0);
    check("mrst_iready", {63'b0, IN_READY}, 64'd1);
    to_pos();
    OUT_READY = 1'b1;
    repeat (4) tick();

    // Random traffic with random stalls; an offered op is held until taken.
    IN_VALID = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!IN_VALID || accepted) begin
        rand_op();
        IN_VALID = ($urandom_range(0, 3) != 0);
      end
      OUT_READY = ($urandom_range(0, 3) != 0);
      tick();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (6) tick();
    check("rand_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
